// File: rtl/zom_spawn_scheduler.sv
// Zombie slot table and frame-paced spawn scheduler with a valid/ready spawn port.
// Optional build macro ZOM_RANDOM_LANE_EN selects LFSR lanes instead of round-robin lanes.
module zom_spawn_scheduler #(
    parameter int N_SLOTS      = 10,
    parameter int SPAWN_PERIOD = 120,
    parameter int LANES        = 5,
    parameter int WAVE_SIZE    = 20
) (
    input  logic                       MAX10_CLK1_50,
    input  logic                       reset_n,
    input  logic                       frame_tick,
    input  logic                       game_run,
    input  logic                       wave_start,
    input  logic [N_SLOTS-1:0]         kill_req,
    input  logic                       spawn_ready,
    output logic                       spawn_valid,
    output logic [$clog2(N_SLOTS)-1:0] spawn_slot,
    output logic [2:0]                 spawn_lane,
    output logic [N_SLOTS-1:0]         zom_active,
    output logic [7:0]                 spawned_cnt,
    output logic                       wave_done
);

    localparam int SLOT_W = $clog2(N_SLOTS);
    localparam int FC_W   = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(SPAWN_PERIOD - 1);
    localparam logic [7:0]      WAVE_LAST = 8'(WAVE_SIZE - 1);
    localparam logic [7:0]      WAVE_CNT  = 8'(WAVE_SIZE);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_ALLOC = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]         state_r, state_s;
    logic [FC_W-1:0]    frame_cnt_r, frame_cnt_s;
    logic               spawn_valid_r, spawn_valid_s;
    logic [SLOT_W-1:0]  spawn_slot_r, spawn_slot_s;
    logic [2:0]         spawn_lane_r, spawn_lane_s;
    logic [N_SLOTS-1:0] zom_active_r, zom_active_s;
    logic [N_SLOTS-1:0] set_mask_s;
    logic [7:0]         spawned_cnt_r, spawned_cnt_s;
    logic               wave_done_r, wave_done_s;
    logic [SLOT_W:0]    free_s;
    logic [2:0]         lane_pick_s;

    // Lowest-index inactive slot; MSB of the result flags that one exists.
    function automatic logic [SLOT_W:0] find_free(input logic [N_SLOTS-1:0] act);
        logic [SLOT_W:0] res;
        res = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            res = act[i] ? res : {1'b1, SLOT_W'(i)};
        end
        return res;
    endfunction

    assign free_s = find_free(zom_active_r);

`ifdef ZOM_RANDOM_LANE_EN
    logic [7:0] lfsr_r;

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    // Fold the 3-bit LFSR sample into the lane range.
    always_comb begin
        lane_pick_s = lfsr_r[2:0];
        if ({1'b0, lfsr_r[2:0]} >= 4'(LANES)) begin
            lane_pick_s = lfsr_r[2:0] - 3'(LANES);
        end else begin
            lane_pick_s = lfsr_r[2:0];
        end
    end
`else
    localparam logic [2:0] LANE_LAST = 3'(LANES - 1);
    logic [2:0] lane_ptr_r, lane_ptr_s;

    assign lane_pick_s = lane_ptr_r;
`endif

    // Next-state logic for the scheduler FSM and the slot table.
    always_comb begin
        state_s       = state_r;
        frame_cnt_s   = frame_cnt_r;
        spawn_valid_s = spawn_valid_r;
        spawn_slot_s  = spawn_slot_r;
        spawn_lane_s  = spawn_lane_r;
        spawned_cnt_s = spawned_cnt_r;
        wave_done_s   = wave_done_r;
        set_mask_s    = '0;
`ifndef ZOM_RANDOM_LANE_EN
        lane_ptr_s    = lane_ptr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (wave_start) begin
                    state_s       = ST_WAIT;
                    spawned_cnt_s = 8'd0;
                    frame_cnt_s   = '0;
                    wave_done_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (frame_tick && game_run) begin
                    if (frame_cnt_r == FC_LAST) begin
                        frame_cnt_s = '0;
                        state_s     = ST_ALLOC;
                    end else begin
                        frame_cnt_s = frame_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            ST_ALLOC: begin
                // Hold here while the table is full; the frame counter is frozen.
                if (free_s[SLOT_W]) begin
                    spawn_slot_s  = free_s[SLOT_W-1:0];
                    spawn_lane_s  = lane_pick_s;
                    spawn_valid_s = 1'b1;
                    state_s       = ST_ISSUE;
                end else begin
                    state_s = ST_ALLOC;
                end
            end
            ST_ISSUE: begin
                if (spawn_valid_r && spawn_ready) begin
                    set_mask_s    = {{(N_SLOTS-1){1'b0}}, 1'b1} << spawn_slot_r;
                    spawn_valid_s = 1'b0;
                    spawned_cnt_s = (spawned_cnt_r < WAVE_CNT) ? spawned_cnt_r + 8'd1 : spawned_cnt_r;
                    state_s       = (spawned_cnt_r >= WAVE_LAST) ? ST_DRAIN : ST_WAIT;
`ifndef ZOM_RANDOM_LANE_EN
                    lane_ptr_s    = (lane_ptr_r == LANE_LAST) ? 3'd0 : lane_ptr_r + 3'd1;
`endif
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (zom_active_r == '0) begin
                    wave_done_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s       = ST_IDLE;
                spawn_valid_s = 1'b0;
            end
        endcase
        // A reserved slot is still inactive, so a kill aimed at it is a no-op.
        zom_active_s = (zom_active_r & ~kill_req) | set_mask_s;
    end

    // State and output registers.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            frame_cnt_r   <= '0;
            spawn_valid_r <= 1'b0;
            spawn_slot_r  <= '0;
            spawn_lane_r  <= 3'd0;
            zom_active_r  <= '0;
            spawned_cnt_r <= 8'd0;
            wave_done_r   <= 1'b0;
`ifndef ZOM_RANDOM_LANE_EN
            lane_ptr_r    <= 3'd0;
`endif
        end else begin
            state_r       <= state_s;
            frame_cnt_r   <= frame_cnt_s;
            spawn_valid_r <= spawn_valid_s;
            spawn_slot_r  <= spawn_slot_s;
            spawn_lane_r  <= spawn_lane_s;
            zom_active_r  <= zom_active_s;
            spawned_cnt_r <= spawned_cnt_s;
            wave_done_r   <= wave_done_s;
`ifndef ZOM_RANDOM_LANE_EN
            lane_ptr_r    <= lane_ptr_s;
`endif
        end
    end

    assign spawn_valid = spawn_valid_r;
    assign spawn_slot  = spawn_slot_r;
    assign spawn_lane  = spawn_lane_r;
    assign zom_active  = zom_active_r;
    assign spawned_cnt = spawned_cnt_r;
    assign wave_done   = wave_done_r;

endmodule

// File: tb/tb_zom_spawn_scheduler.sv
// Scoreboard bench for zom_spawn_scheduler (round-robin lane build).
module tb_zom_spawn_scheduler;

    localparam int N_SLOTS = 10;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               frame_tick = 1'b0;
    logic               game_run = 1'b1;
    logic               wave_start = 1'b0;
    logic [N_SLOTS-1:0] kill_req = '0;
    logic               spawn_ready = 1'b1;
    logic               spawn_valid;
    logic [3:0]         spawn_slot;
    logic [2:0]         spawn_lane;
    logic [N_SLOTS-1:0] zom_active;
    logic [7:0]         spawned_cnt;
    logic               wave_done;

    typedef struct {
        logic [3:0] slot;
        logic [2:0] lane;
        int         rise;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;

    zom_spawn_scheduler #(
        .N_SLOTS(N_SLOTS), .SPAWN_PERIOD(3), .LANES(5), .WAVE_SIZE(12)
    ) dut (
        .MAX10_CLK1_50(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .game_run(game_run), .wave_start(wave_start), .kill_req(kill_req),
        .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .spawn_slot(spawn_slot),
        .spawn_lane(spawn_lane), .zom_active(zom_active), .spawned_cnt(spawned_cnt),
        .wave_done(wave_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented command must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (spawn_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    if (!prev_v) check("valid_rise_cycle", cyc, q[0].rise);
                    check("spawn_cmd", {spawn_slot, spawn_lane}, {q[0].slot, q[0].lane});
                    if (spawn_ready) void'(q.pop_front());
                end
            end
            prev_v = spawn_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic push_exp(input int slot, input int lane, input int rise);
        exp_t e;
        e.slot = slot[3:0];
        e.lane = lane[2:0];
        e.rise = rise;
        q.push_back(e);
    endtask

    // Three ticks; the third one qualifies, so valid rises two cycles later.
    task automatic do_period(input int slot, input int lane, input bit expect_spawn);
        pulse_tick();
        pulse_tick();
        frame_tick = 1'b1;
        if (expect_spawn) push_exp(slot, lane, cyc + 2);
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic start_wave();
        wave_start = 1'b1;
        step();
        wave_start = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check("rst_valid", {31'd0, spawn_valid}, 32'd0);
        check("rst_active", {22'd0, zom_active}, 32'd0);
        check("rst_cnt", {24'd0, spawned_cnt}, 32'd0);
        check("rst_wave_done", {31'd0, wave_done}, 32'd0);
        check("rst_slot_lane", {25'd0, spawn_slot, spawn_lane}, 32'd0);
        reset_n = 1'b1;
        step();

        // T1: reset while a command is waiting for ready.
        spawn_ready = 1'b0;
        start_wave();
        do_period(0, 0, 1'b1);
        repeat (3) step();
        check("t1_pre_valid", {31'd0, spawn_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t1_async_valid", {31'd0, spawn_valid}, 32'd0);
        check("t1_async_active", {22'd0, zom_active}, 32'd0);
        check("t1_async_cnt", {24'd0, spawned_cnt}, 32'd0);
        q.delete();
        step();
        step();
        reset_n = 1'b1;
        spawn_ready = 1'b1;
        step();
        do_period(0, 0, 1'b0);
        repeat (4) step();
        check("t1_idle_no_valid", {31'd0, spawn_valid}, 32'd0);

        // T2: fill all ten slots, round-robin lanes.
        start_wave();
        for (int k = 0; k < 10; k++) begin
            do_period(k, k % 5, 1'b1);
            repeat (3) step();
            if (k == 0) check("t2_first_active", {22'd0, zom_active}, 32'h001);
        end
        check("t2_full_active", {22'd0, zom_active}, 32'h3FF);
        check("t2_cnt10", {24'd0, spawned_cnt}, 32'd10);

        // T3: table full, period expires, then a kill frees slot 6.
        do_period(0, 0, 1'b0);
        pulse_tick();
        pulse_tick();
        repeat (6) step();
        check("t3_hold_no_valid", {31'd0, spawn_valid}, 32'd0);
        kill_req = 10'h040;
        push_exp(6, 0, cyc + 2);
        step();
        kill_req = '0;
        repeat (4) step();
        check("t3_active", {22'd0, zom_active}, 32'h3FF);
        check("t3_cnt11", {24'd0, spawned_cnt}, 32'd11);

        // T4/T6: stalled handshake, game_run toggling, kill on the reserved slot.
        kill_req = 10'h004;
        step();
        kill_req = '0;
        step();
        spawn_ready = 1'b0;
        do_period(2, 1, 1'b1);
        for (int i = 0; i < 50; i++) begin
            game_run   = i[0];
            kill_req   = (i == 10) ? 10'h004 : 10'h000;
            frame_tick = (i == 20) ? 1'b1 : 1'b0;
            step();
            if (i == 30) check("t6_reserved_inactive", {22'd0, zom_active}, 32'h3FB);
        end
        kill_req = '0;
        frame_tick = 1'b0;
        game_run = 1'b1;
        check("t4_valid_held", {31'd0, spawn_valid}, 32'd1);
        spawn_ready = 1'b1;
        step();
        step();
        check("t6_active_after_xfer", {22'd0, zom_active}, 32'h3FF);
        check("t4_cnt12", {24'd0, spawned_cnt}, 32'd12);
        check("t4_valid_low", {31'd0, spawn_valid}, 32'd0);

        // T5: wave fully spawned; drain by killing every slot.
        check("t5_not_done", {31'd0, wave_done}, 32'd0);
        kill_req = 10'h01F;
        step();
        kill_req = 10'h3E0;
        check("t5_half_active", {22'd0, zom_active}, 32'h3E0);
        step();
        kill_req = '0;
        check("t5_empty", {22'd0, zom_active}, 32'h000);
        check("t5_done_late", {31'd0, wave_done}, 32'd0);
        step();
        check("t5_done", {31'd0, wave_done}, 32'd1);
        repeat (3) step();
        check("t5_done_held", {31'd0, wave_done}, 32'd1);

        // Restart from wave_done; lane pointer continues after twelve transfers.
        start_wave();
        check("restart_done_clr", {31'd0, wave_done}, 32'd0);
        check("restart_cnt_clr", {24'd0, spawned_cnt}, 32'd0);
        do_period(0, 2, 1'b1);
        repeat (3) step();
        check("restart_active", {22'd0, zom_active}, 32'h001);
        check("restart_cnt", {24'd0, spawned_cnt}, 32'd1);

        repeat (2) step();
        check("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
